// File: rtl/buffet_stencil_read_agen_pkg.sv
// Shared state encoding and counter-width helpers for the buffet stencil read
// address generator.
package buffet_agen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE  = 3'd1;
  localparam state_t ST_DRAIN  = 3'd2;
  localparam state_t ST_SHRINK = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // A counter for n distinct values never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IMG_W   = 64;
  localparam int DEF_IMG_H   = 64;
  localparam int DEF_TAPS    = 3;
  localparam int DEF_MAX_OUT = 2;

  localparam int DEF_X_W   = cnt_w(DEF_IMG_W);
  localparam int DEF_TAP_W = cnt_w(DEF_TAPS);
  localparam int DEF_ROW_W = cnt_w(DEF_IMG_H);
  localparam int DEF_OUT_W = cnt_w(DEF_MAX_OUT + 1);

endpackage

// File: rtl/buffet_stencil_read_agen_if.sv
// Buffet read/shrink ports plus the downstream SIPO stream, seen from the
// address generator (master) or from the buffet/SIPO side (slave).
interface buffet_stencil_read_agen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16
);

  logic [IDX_WIDTH-1:0]  read_idx;
  logic                  read_idx_valid;
  logic                  read_idx_ready;
  logic                  read_will_update;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_valid;
  logic                  read_data_ready;
  logic                  shrink_valid;
  logic [IDX_WIDTH-1:0]  shrink_size;
  logic                  shrink_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output read_idx, read_idx_valid, read_will_update,
    input  read_idx_ready,
    input  read_data, read_data_valid,
    output read_data_ready,
    output shrink_valid, shrink_size,
    input  shrink_ready,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  read_idx, read_idx_valid, read_will_update,
    output read_idx_ready,
    output read_data, read_data_valid,
    input  read_data_ready,
    input  shrink_valid, shrink_size,
    output shrink_ready,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/buffet_rd_skid_fifo.sv
// Small skid FIFO between buffet return data and the SIPO stream; no
// same-cycle bypass, so a push into an empty FIFO shows up one cycle later.
module buffet_rd_skid_fifo
  import buffet_agen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_w(DEPTH + 1)-1:0]   count
);

  localparam int PW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO is fine as long as a pop frees a slot that cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/buffet_stencil_read_agen.sv
// Read-side controller for a line-buffer buffet feeding a TAPS-row stencil:
// issues column-major reads per output row, streams returns, shrinks per row.
module buffet_stencil_read_agen
  import buffet_agen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int TAPS       = 3,
  parameter int MAX_OUT    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  buffet_stencil_read_agen_if.master bus
);

  localparam int XW = cnt_w(IMG_W);
  localparam int TW = cnt_w(TAPS);
  localparam int RW = cnt_w(IMG_H);
  localparam int OW = cnt_w(MAX_OUT + 1);

  if (longint'(TAPS) * longint'(IMG_W) > (64'd1 << IDX_WIDTH)) begin : g_idx_range
    $error("TAPS*IMG_W does not fit in IDX_WIDTH bits");
  end

  state_t                state;
  logic [XW-1:0]         x;
  logic [TW-1:0]         r;
  logic [RW-1:0]         row;
  logic [OW-1:0]         inflight;
  logic [OW-1:0]         fifo_count;
  logic [OW:0]           occupancy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  idx_hs;
  logic                  out_hs;
  logic                  last_tap;
  logic                  last_col;

  // Credit: reads in flight plus words parked in the FIFO never exceed MAX_OUT,
  // so every return has a guaranteed slot.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign idx_hs    = bus.read_idx_valid && bus.read_idx_ready;
  assign out_hs    = bus.out_valid && bus.out_ready;
  assign last_tap  = (r == TW'(TAPS - 1));
  assign last_col  = (x == XW'(IMG_W - 1));

  assign bus.read_idx_valid   = (state == ST_ISSUE) && (occupancy < (OW + 1)'(MAX_OUT));
  assign bus.read_idx         = (state == ST_ISSUE) ?
                                IDX_WIDTH'(r) * IDX_WIDTH'(IMG_W) + IDX_WIDTH'(x) : '0;
  assign bus.read_will_update = 1'b0;
  assign bus.read_data_ready  = !fifo_full;
  assign bus.shrink_valid     = (state == ST_SHRINK);
  assign bus.shrink_size      = IDX_WIDTH'(IMG_W);
  assign bus.out_valid        = !fifo_empty;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE) && fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      x     <= '0;
      r     <= '0;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            x     <= '0;
            r     <= '0;
            row   <= '0;
          end
        end
        ST_ISSUE: begin
          if (idx_hs) begin
            if (last_tap) begin
              r <= '0;
              if (last_col) begin
                x     <= '0;
                state <= ST_DRAIN;
              end else begin
                x <= x + 1'b1;
              end
            end else begin
              r <= r + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (inflight == '0)
            state <= (row < RW'(IMG_H - TAPS)) ? ST_SHRINK : ST_DONE;
        end
        ST_SHRINK: begin
          if (bus.shrink_ready) begin
            row   <= row + 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          if (fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({idx_hs, bus.read_data_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  inflight_bound: assert property (@(posedge clk) disable iff (reset)
    inflight <= OW'(MAX_OUT));

  buffet_rd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OUT)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.read_data_valid),
    .push_data (bus.read_data),
    .pop       (out_hs),
    .pop_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/buffet_stencil_read_agen.md
Name: buffet_stencil_read_agen

Overview:
- Read-side controller for a line-buffer buffet feeding a 3-row stencil.
- Generates the buffet read_idx sequence for each output row and collects the returned read_data in order.
- Streams the words as a scalar valid/ready stream into the downstream SIPO shift register.
- Issues a shrink request after each completed output row so the buffet frees the oldest line.

Parameters:
- DATA_WIDTH, 16, width of buffet data words
- IDX_WIDTH, 16, width of buffet read index
- IMG_W, 64, image width in words (line length)
- IMG_H, 64, image height in lines
- TAPS, 3, stencil rows read per column
- MAX_OUT, 2, maximum in-flight reads; also the skid FIFO depth

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the frame completes
- read_idx  out  IDX_WIDTH  buffet read index
- read_idx_valid  out  1  index valid
- read_idx_ready  in  1  buffet accepts index
- read_will_update  out  1  constant 0
- read_data  in  DATA_WIDTH  buffet return data
- read_data_valid  in  1  return data valid
- read_data_ready  out  1  high whenever the skid FIFO is not full
- shrink_valid  out  1  request to free IMG_W words at the buffet head
- shrink_size  out  IDX_WIDTH  constant IMG_W
- shrink_ready  in  1  buffet accepts shrink
- out_data  out  DATA_WIDTH  stream to SIPO
- out_valid  out  1  stream valid
- out_ready  in  1  SIPO ready

Behaviour:
- Reset values (synchronous, priority over all else): FSM=IDLE, all counters=0, skid FIFO empty, every valid/busy/done output=0, read_idx=0.
- FSM states: IDLE, ISSUE, DRAIN, SHRINK, DONE.
  - IDLE: start -> ISSUE; x=r=row=0.
  - ISSUE: read_idx = r*IMG_W + x. Index is relative to the buffet head, independent of row. Computed in IDX_WIDTH bits; elaboration check that TAPS*IMG_W <= 2^IDX_WIDTH.
  - ISSUE: read_idx_valid=1 iff inflight + fifo_count < MAX_OUT.
  - ISSUE: on a read_idx handshake, r increments first; at r=TAPS-1, r wraps to 0 and x increments. After the handshake at x=IMG_W-1, r=TAPS-1 -> DRAIN.
  - DRAIN: wait until inflight==0. Then, if row < IMG_H-TAPS -> SHRINK, else -> DONE.
  - SHRINK: shrink_valid=1 until shrink_ready. On the handshake, row++ -> ISSUE. Count is IMG_H-TAPS shrinks per frame.
  - DONE: wait until the FIFO is empty, pulse done for one cycle -> IDLE.
- Order of issue within a row: per column x, rows r=0..TAPS-1. The output stream is emitted in the same order. Total reads per frame = (IMG_H-TAPS+1)*IMG_W*TAPS.
- inflight counter:
  - +1 on a read_idx handshake, -1 on read_data_valid (always accepted, since credit guarantees FIFO space).
  - Simultaneous +1/-1 leaves it unchanged.
  - Never exceeds MAX_OUT; exceeding it is an assertion failure.
- Skid FIFO, depth MAX_OUT:
  - Push on read_data_valid, pop on out_valid && out_ready.
  - Simultaneous push/pop is legal when full and when empty: a push on empty is not visible the same cycle (no bypass).
  - out_valid = !empty.
- Output latency: out_valid appears 1 cycle after read_data_valid.
- Backpressure: with out_ready low, the FIFO fills and issue stalls. No data is lost or duplicated.
- start while busy is ignored. A reset mid-frame aborts; in-flight returns after reset are dropped, and the buffet is reset together with this block.

Decomposition:
- Package buffet_agen_pkg holds:
  - state enum typedef
  - localparams for counter widths ($clog2 of IMG_W, TAPS, IMG_H, MAX_OUT+1)
- Sub-module buffet_rd_skid_fifo (parameters DATA_WIDTH, DEPTH; push/pop/full/empty/count).

Test Plan (IMG_W=4, IMG_H=4, TAPS=3, MAX_OUT=2; buffet model returns data=idx+0x100 after 2 cycles):
- Free-running, out_ready=1, start pulse -> 24 idx issued.
  - Row 0 order: 0,4,8,1,5,9,2,6,10,3,7,11; row 1 repeats.
  - Exactly 1 shrink (size 4) between rows.
  - done one cycle after the last out word.
- Output stream check -> out_data equals 0x100,0x104,0x108,0x101,... in order, 24 words, no gaps beyond the latency.
- out_ready=0 for 20 cycles mid-row -> at most 2 reads outstanding, FIFO holds 2, read_idx_valid low. On resume the stream continues without loss or duplication.
- shrink_ready held low 10 cycles -> shrink_valid stays high and stable, no read_idx issued until the handshake.
- Reset asserted at read 7 -> next cycle all outputs 0 and state IDLE. A fresh start replays the sequence from idx 0.
- start pulsed while busy -> ignored; total read count stays 24 and done pulses once.
